axi_w_burst_buffer: RTL and testbench
=====================================

Name: axi_w_burst_buffer

Overview:
- Parametrised AXI write-data (W) channel buffer, the successor to the single-slice W buffer.
- Sits between an AXI master port and the downstream interconnect or slave on the W channel.
- Adds a configurable-depth FIFO, selectable cut-through or store-and-forward release, complete-burst counting and fill-level status.
- Store-and-forward mode guarantees that downstream W bursts are gap-free once started, except when a burst exceeds the FIFO depth.

Parameters:
- DATA_WIDTH, 64, W data width in bits; multiple of 8.
- USER_WIDTH, 1, W user width in bits; at least 1.
- STRB_WIDTH, DATA_WIDTH/8, strobe width.
- DEPTH, 8, FIFO entries; at least 2; need not be a power of two.
- STORE_FWD, 0, 0 = cut-through, 1 = store-and-forward.
- CNT_W, clog2(DEPTH+1), width of the status counters.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- slave_valid_i  in  1  input beat valid.
- slave_data_i  in  DATA_WIDTH  input W data.
- slave_strb_i  in  STRB_WIDTH  input W strobe.
- slave_user_i  in  USER_WIDTH  input W user.
- slave_last_i  in  1  input W last.
- slave_ready_o  out  1  buffer can accept a beat.
- master_valid_o  out  1  output beat valid.
- master_data_o  out  DATA_WIDTH  output W data.
- master_strb_o  out  STRB_WIDTH  output W strobe.
- master_user_o  out  USER_WIDTH  output W user.
- master_last_o  out  1  output W last.
- master_ready_i  in  1  downstream accepts the beat.
- fill_o  out  CNT_W  number of beats stored.
- bursts_o  out  CNT_W  number of complete bursts stored, i.e. stored last beats.
- forced_o  out  1  oversize-burst forced release active (store-and-forward only).

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - fill_o = 0, bursts_o = 0, forced_o = 0, master_valid_o = 0.
  - slave_ready_o = 1 on the first cycle after reset.
  - Pointers are cleared.
  - Data outputs are don't-care while master_valid_o = 0. The storage array is not reset.
- Reset mid-burst drops all stored beats; upstream and downstream must also be reset.
- Push and pop:
  - push = slave_valid_i & slave_ready_o.
  - pop = master_valid_o & master_ready_i.
  - slave_ready_o = (fill_o < DEPTH). It is registered/derived from state only and never depends on slave_valid_i or master_ready_i.
  - When full there is no pass-through: a pop does not enable a same-cycle push.
- Latency:
  - A beat pushed in cycle N is presentable at master_* in cycle N+1 at the earliest.
  - There is no combinational path from slave_* to master_*.
- Stored word: {user, strb, data, last}, kept in circular storage.
  - Read and write pointers wrap from DEPTH-1 to 0.
  - Outputs are driven from the entry at the read pointer.
- fill_o:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop, including when fill_o = 1.
- bursts_o:
  - +1 on a push with last = 1.
  - -1 on a pop with master_last_o = 1.
  - Both in the same cycle: unchanged.
- Cut-through mode (STORE_FWD = 0):
  - master_valid_o = (fill_o != 0).
  - forced_o is tied to 0.
- Store-and-forward mode (STORE_FWD = 1), two-state FSM:
  - IDLE:
    - master_valid_o = (fill_o != 0) & (bursts_o != 0).
    - IDLE -> FORCE when fill_o == DEPTH and bursts_o == 0. This is an oversize burst; releasing it prevents deadlock.
  - FORCE:
    - forced_o = 1.
    - master_valid_o = (fill_o != 0).
    - FORCE -> IDLE on a pop with master_last_o = 1.
    - Beats following that last return to gated behaviour.
- Handshake invariants:
  - Once master_valid_o rises, it and master_* stay stable until pop.
  - In store-and-forward mode this holds because bursts_o and FORCE never drop without a pop.
  - slave_valid_i may be asserted without waiting for slave_ready_o.
- Zero-length bursts do not exist. Every last = 1 beat closes a burst, so single-beat bursts count immediately.

Test Plan:
- Cut-through, DEPTH = 4:
  - Stimulus: push 1 beat (data = 0xA5, last = 1) in cycle 0, master_ready_i = 1.
  - Required: master_valid_o = 1 in cycle 1 with data 0xA5; fill_o returns to 0 in cycle 2; bursts_o pulses 1 then returns to 0.
- Full and back-pressure, DEPTH = 4, master_ready_i = 0:
  - Stimulus: push 6 beats.
  - Required: exactly 4 accepted; slave_ready_o = 0 with fill_o = 4. One pop re-enables slave_ready_o the following cycle, never the same cycle. The read order across pointer wrap equals the push order.
- Store-and-forward, DEPTH = 8:
  - Stimulus: push 3 beats, last on the 3rd.
  - Required: master_valid_o stays 0 until the cycle after the 3rd push; then 3 consecutive beats pop with no gaps when master_ready_i = 1.
- Store-and-forward oversize burst, DEPTH = 4:
  - Stimulus: push a 6-beat burst.
  - Required: at fill_o = 4 with bursts_o = 0, forced_o = 1 and beats drain. forced_o clears after the last beat pops. A following 2-beat burst is held until its last beat is stored.
- Simultaneous push/pop:
  - Stimulus: in store-and-forward mode with bursts_o = 1, push a last beat while popping a last beat.
  - Required: bursts_o stays 1 and fill_o is unchanged.
- Reset mid-burst:
  - Stimulus: assert rst_i for 1 cycle with fill_o = 3 and FORCE active.
  - Required: the next cycle shows fill_o = 0, bursts_o = 0, forced_o = 0, master_valid_o = 0, slave_ready_o = 1.

Source files
------------

// File: rtl/axi_w_burst_buffer.sv
// AXI W-channel burst buffer: circular FIFO with cut-through or store-and-forward release,
// fill and complete-burst counters, and forced release of bursts larger than the FIFO.
module axi_w_burst_buffer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned STORE_FWD  = 0,
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  slave_valid_i,
    input  logic [DATA_WIDTH-1:0] slave_data_i,
    input  logic [STRB_WIDTH-1:0] slave_strb_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    input  logic                  slave_last_i,
    output logic                  slave_ready_o,

    output logic                  master_valid_o,
    output logic [DATA_WIDTH-1:0] master_data_o,
    output logic [STRB_WIDTH-1:0] master_strb_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic                  master_last_o,
    input  logic                  master_ready_i,

    output logic [CNT_W-1:0]      fill_o,
    output logic [CNT_W-1:0]      bursts_o,
    output logic                  forced_o
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WORD_W = USER_WIDTH + STRB_WIDTH + DATA_WIDTH + 1;

    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {StIdle, StForce} state_e;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  fill_q;
    logic [CNT_W-1:0]  bursts_q;
    state_e            state_q;

    logic push;
    logic pop;
    logic burst_in;
    logic burst_out;
    logic has_data;

    assign slave_ready_o = (fill_q < FULL);
    assign has_data      = (fill_q != '0);
    assign fill_o        = fill_q;
    assign bursts_o      = bursts_q;
    assign forced_o      = (state_q == StForce);

    // Store-and-forward only releases complete bursts unless an oversize burst is being forced.
    always_comb begin
        master_valid_o = has_data;
        if (STORE_FWD != 0) begin
            master_valid_o = has_data && ((bursts_q != '0) || (state_q == StForce));
        end
    end

    assign {master_user_o, master_strb_o, master_data_o, master_last_o} = mem_q[rd_ptr_q];

    assign push      = slave_valid_i && slave_ready_o;
    assign pop       = master_valid_o && master_ready_i;
    assign burst_in  = push && slave_last_i;
    assign burst_out = pop && master_last_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {slave_user_i, slave_strb_i, slave_data_i, slave_last_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            bursts_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                fill_q <= fill_q + CNT_W'(1);
            end else if (!push && pop) begin
                fill_q <= fill_q - CNT_W'(1);
            end
            if (burst_in && !burst_out) begin
                bursts_q <= bursts_q + CNT_W'(1);
            end else if (!burst_in && burst_out) begin
                bursts_q <= bursts_q - CNT_W'(1);
            end
        end
    end

    // A full FIFO holding no last beat can never complete its burst, so release it until its
    // last beat leaves.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if ((STORE_FWD != 0) && (fill_q == FULL) && (bursts_q == '0)) begin
                        state_q <= StForce;
                    end
                end
                StForce: begin
                    if (burst_out) begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_w_burst_buffer.sv
// Randomized and directed bench for axi_w_burst_buffer: one cut-through and one
// store-and-forward instance, each checked every cycle against a queue-based model.
module tb_axi_w_burst_buffer;

    localparam int unsigned DW    = 16;
    localparam int unsigned UW    = 2;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [UW-1:0] user;
        logic [SW-1:0] strb;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0: cut-through, index 1: store-and-forward.
    logic          s_valid  [2];
    logic [DW-1:0] s_data   [2];
    logic [SW-1:0] s_strb   [2];
    logic [UW-1:0] s_user   [2];
    logic          s_last   [2];
    logic          s_ready  [2];
    logic          m_valid  [2];
    logic [DW-1:0] m_data   [2];
    logic [SW-1:0] m_strb   [2];
    logic [UW-1:0] m_user   [2];
    logic          m_last   [2];
    logic          rdy      [2];
    logic [CW-1:0] m_fill   [2];
    logic [CW-1:0] m_bursts [2];
    logic          m_forced [2];

    axi_w_burst_buffer #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DEPTH), .STORE_FWD(0)
    ) u_ct (
        .clk_i(clk), .rst_i(rst),
        .slave_valid_i(s_valid[0]), .slave_data_i(s_data[0]), .slave_strb_i(s_strb[0]),
        .slave_user_i(s_user[0]), .slave_last_i(s_last[0]), .slave_ready_o(s_ready[0]),
        .master_valid_o(m_valid[0]), .master_data_o(m_data[0]), .master_strb_o(m_strb[0]),
        .master_user_o(m_user[0]), .master_last_o(m_last[0]), .master_ready_i(rdy[0]),
        .fill_o(m_fill[0]), .bursts_o(m_bursts[0]), .forced_o(m_forced[0])
    );

    axi_w_burst_buffer #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DEPTH), .STORE_FWD(1)
    ) u_sf (
        .clk_i(clk), .rst_i(rst),
        .slave_valid_i(s_valid[1]), .slave_data_i(s_data[1]), .slave_strb_i(s_strb[1]),
        .slave_user_i(s_user[1]), .slave_last_i(s_last[1]), .slave_ready_o(s_ready[1]),
        .master_valid_o(m_valid[1]), .master_data_o(m_data[1]), .master_strb_o(m_strb[1]),
        .master_user_o(m_user[1]), .master_last_o(m_last[1]), .master_ready_i(rdy[1]),
        .fill_o(m_fill[1]), .bursts_o(m_bursts[1]), .forced_o(m_forced[1])
    );

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t mq [2][$];
    bit    mf [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned n_last(input int k);
        int unsigned n = 0;
        for (int i = 0; i < mq[k].size(); i++) begin
            if (mq[k][i].last) n++;
        end
        return n;
    endfunction

    function automatic bit mdl_ready(input int k);
        return mq[k].size() < DEPTH;
    endfunction

    function automatic bit mdl_valid(input int k);
        if (mq[k].size() == 0) return 1'b0;
        if (k == 0) return 1'b1;
        return mf[k] || (n_last(k) != 0);
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            string p = (k == 0) ? "ct" : "sf";
            check({p, "_ready"}, s_ready[k], mdl_ready(k));
            check({p, "_valid"}, m_valid[k], mdl_valid(k));
            check({p, "_fill"}, m_fill[k], mq[k].size());
            check({p, "_bursts"}, m_bursts[k], n_last(k));
            check({p, "_forced"}, m_forced[k], mf[k]);
            if (mdl_valid(k)) begin
                check({p, "_data"}, m_data[k], mq[k][0].data);
                check({p, "_strb"}, m_strb[k], mq[k][0].strb);
                check({p, "_user"}, m_user[k], mq[k][0].user);
                check({p, "_last"}, m_last[k], mq[k][0].last);
            end
        end
    endtask

    // One clock: model reacts to the inputs present before the edge, then outputs are compared.
    task automatic tick();
        bit    push [2];
        bit    pop  [2];
        beat_t in_b [2];
        beat_t hd   [2];
        for (int k = 0; k < 2; k++) begin
            push[k] = s_valid[k] && mdl_ready(k);
            pop[k]  = rdy[k] && mdl_valid(k);
            in_b[k] = '{user: s_user[k], strb: s_strb[k], data: s_data[k], last: s_last[k]};
            hd[k]   = (mq[k].size() != 0) ? mq[k][0] : '0;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                mf[k] = 1'b0;
            end else begin
                if (k == 1) begin
                    if (!mf[k] && mq[k].size() == DEPTH && n_last(k) == 0) mf[k] = 1'b1;
                    else if (mf[k] && pop[k] && hd[k].last) mf[k] = 1'b0;
                end
                if (pop[k]) void'(mq[k].pop_front());
                if (push[k]) mq[k].push_back(in_b[k]);
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic put(input int k, input logic [DW-1:0] d, input logic l);
        s_valid[k] = 1'b1;
        s_data[k]  = d;
        s_strb[k]  = SW'($urandom);
        s_user[k]  = UW'($urandom);
        s_last[k]  = l;
    endtask

    task automatic idle(input int k);
        s_valid[k] = 1'b0;
    endtask

    initial begin
        int i;
        int guard;
        bit acc;
        bit forced_seen;
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 0; s_data[k] = '0; s_strb[k] = '0; s_user[k] = '0; s_last[k] = 0;
            rdy[k] = 0; mf[k] = 0;
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_fill", m_fill[0], 0);
        check("rst_valid", m_valid[1], 0);
        check("rst_ready", s_ready[1], 1);

        // Cut-through single beat.
        rdy[0] = 1'b1;
        put(0, 16'h00A5, 1'b1);
        tick();
        idle(0);
        check("ct_first_valid", m_valid[0], 1);
        check("ct_first_data", m_data[0], 16'h00A5);
        check("ct_first_bursts", m_bursts[0], 1);
        tick();
        check("ct_first_fill0", m_fill[0], 0);
        check("ct_first_bursts0", m_bursts[0], 0);

        // Cut-through full / back-pressure, pointers wrap.
        rdy[0] = 1'b0;
        for (int b = 0; b < 6; b++) begin
            put(0, DW'(16'h0010 + b), b == 5);
            tick();
        end
        idle(0);
        check("ct_full_fill", m_fill[0], 4);
        check("ct_full_ready", s_ready[0], 0);
        rdy[0] = 1'b1;
        #1;
        check("ct_no_passthru", s_ready[0], 0);
        tick();
        check("ct_reopen_ready", s_ready[0], 1);
        check("ct_reopen_fill", m_fill[0], 3);
        for (int b = 0; b < 3; b++) tick();
        check("ct_drained", m_fill[0], 0);

        // Store-and-forward three-beat burst.
        rdy[1] = 1'b1;
        put(1, 16'h0030, 1'b0); tick();
        check("sf_gate0", m_valid[1], 0);
        put(1, 16'h0031, 1'b0); tick();
        check("sf_gate1", m_valid[1], 0);
        put(1, 16'h0032, 1'b1); tick();
        idle(1);
        check("sf_release", m_valid[1], 1);
        for (int b = 0; b < 3; b++) begin
            check("sf_gapfree", m_valid[1], 1);
            tick();
        end
        check("sf_done", m_valid[1], 0);

        // Store-and-forward oversize burst.
        i = 0; guard = 0; forced_seen = 0;
        while (i < 6 && guard < 50) begin
            put(1, DW'(16'h0100 + i), i == 5);
            acc = s_ready[1];
            tick();
            if (m_forced[1]) forced_seen = 1;
            if (acc) i++;
            guard++;
        end
        idle(1);
        check("sf_oversize_accepted", i, 6);
        check("sf_forced_seen", forced_seen, 1);
        guard = 0;
        while (m_fill[1] != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("sf_oversize_drained", m_fill[1], 0);
        check("sf_forced_clear", m_forced[1], 0);

        // Following 2-beat burst held until its last beat is stored.
        rdy[1] = 1'b0;
        put(1, 16'h0200, 1'b0); tick();
        idle(1);
        check("sf_hold", m_valid[1], 0);
        put(1, 16'h0201, 1'b1); tick();
        idle(1);
        check("sf_hold_release", m_valid[1], 1);

        // Simultaneous push and pop of last beats.
        rdy[1] = 1'b1;
        tick();
        check("sf_head_last_bursts", m_bursts[1], 1);
        put(1, 16'h0202, 1'b1);
        tick();
        idle(1);
        check("sf_simul_bursts", m_bursts[1], 1);
        check("sf_simul_fill", m_fill[1], 1);
        tick();
        check("sf_simul_drained", m_fill[1], 0);

        // Reset mid-burst while forced.
        rdy[1] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            put(1, DW'(16'h0300 + b), 1'b0);
            tick();
        end
        idle(1);
        tick();
        rdy[1] = 1'b1;
        tick();
        rdy[1] = 1'b0;
        check("sf_pre_rst_fill", m_fill[1], 3);
        check("sf_pre_rst_forced", m_forced[1], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sf_rst_fill", m_fill[1], 0);
        check("sf_rst_bursts", m_bursts[1], 0);
        check("sf_rst_forced", m_forced[1], 0);
        check("sf_rst_valid", m_valid[1], 0);
        check("sf_rst_ready", s_ready[1], 1);

        // Randomized traffic on both instances.
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                s_valid[k] = ($urandom_range(0, 9) < 7);
                s_data[k]  = DW'($urandom);
                s_strb[k]  = SW'($urandom);
                s_user[k]  = UW'($urandom);
                s_last[k]  = ($urandom_range(0, 3) == 0);
                rdy[k]     = ($urandom_range(0, 9) < 6);
            end
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
